// File: rtl/panel_ctrl_pkg.sv
// Shared definitions for the front-panel controller: FSM state encoding,
// default timing parameters and a counter-width helper.
package panel_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUSY     = 2'd1,
    ST_DONE_OK  = 2'd2,
    ST_DONE_ERR = 2'd3
  } state_e;

`ifdef COCOTB_SIM
  localparam int DEF_DEB_CYCLES     = 4;
  localparam int DEF_TIMEOUT_CYCLES = 100;
  localparam int DEF_BLINK_HALF     = 8;
`else
  // 10 ms debounce, 30 s watchdog, 0.25 s blink half-period at 36 MHz
  localparam int DEF_DEB_CYCLES     = 360000;
  localparam int DEF_TIMEOUT_CYCLES = 36000000 * 30;
  localparam int DEF_BLINK_HALF     = 9000000;
`endif

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/panel_ctrl_if.sv
// Board-side pins of the front panel plus the ghost_sd handshake.
// master = panel_ctrl, slave = the board / ghost_sd side.
interface panel_ctrl_if;
  logic ibtn;
  logic isuccess;
  logic ifail;
  logic ostart;
  logic oled_busy;
  logic oled_ok;
  logic oled_err;
  logic otimeout;

  modport master (
    input  ibtn, isuccess, ifail,
    output ostart, oled_busy, oled_ok, oled_err, otimeout
  );

  modport slave (
    output ibtn, isuccess, ifail,
    input  ostart, oled_busy, oled_ok, oled_err, otimeout
  );
endinterface

// File: rtl/panel_ctrl_debounce.sv
// Start-button conditioning: 2-flop synchronizer followed by a counter that
// only accepts a level change after DEB_CYCLES consecutive disagreeing
// samples. press is a registered one-cycle pulse on the accepted rise.
module debounce
  import panel_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic iclk,
  input  logic irst,
  input  logic ibtn,
  output logic btn_d,
  output logic press
);

  localparam int CW = cnt_w(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          btn_d_q, btn_d_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  // Next-state: count disagreement, toggle the level once the count is full.
  always_comb begin
    sync1_d = ibtn;
    sync2_d = sync1_q;
    btn_d_d = btn_d_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != btn_d_q) begin
      if (cnt_q == CNT_LAST) begin
        btn_d_d = ~btn_d_q;
        press_d = ~btn_d_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge iclk) begin
    if (!irst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      btn_d_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      btn_d_q <= btn_d_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign btn_d = btn_d_q;
  assign press = press_q;

endmodule

// File: rtl/panel_ctrl.sv
// Front-panel controller: debounced start button -> one-cycle ostart,
// run FSM latching ghost_sd results, run watchdog and LED blink patterns.
// Every output is a flop; LED values are derived from next-state values so
// they change on the same edge as the state.
module panel_ctrl
  import panel_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES     = DEF_DEB_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int BLINK_HALF     = DEF_BLINK_HALF
) (
  input  logic          iclk,
  input  logic          irst,
  panel_ctrl_if.master  pif
);

  localparam int WW = cnt_w(TIMEOUT_CYCLES);
  localparam int BW = cnt_w(BLINK_HALF);
  localparam logic [WW-1:0] WD_LAST    = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  logic btn_lvl;
  logic press;
  logic start_req;

  debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_debounce (
    .iclk  (iclk),
    .irst  (irst),
    .ibtn  (pif.ibtn),
    .btn_d (btn_lvl),
    .press (press)
  );

  // press only ever accompanies a high debounced level; gating keeps the pair coherent
  assign start_req = press & btn_lvl;

  state_e        state_q,   state_d;
  logic          ostart_q,  ostart_d;
  logic          busy_q,    busy_d;
  logic          ok_q,      ok_d;
  logic          err_q,     err_d;
  logic          timeout_q, timeout_d;
  logic          phase_q,   phase_d;
  logic [WW-1:0] wd_q,      wd_d;
  logic [BW-1:0] blink_q,   blink_d;

  // Next-state: free-running blink, FSM transitions, watchdog, LED decode.
  always_comb begin
    state_d   = state_q;
    ostart_d  = 1'b0;
    timeout_d = timeout_q;
    wd_d      = wd_q;

    if (blink_q == BLINK_LAST) begin
      blink_d = '0;
      phase_d = ~phase_q;
    end else begin
      blink_d = blink_q + BW'(1);
      phase_d = phase_q;
    end

    case (state_q)
      ST_BUSY: begin
        // a result flag beats watchdog expiry; ifail beats isuccess
        if (pif.ifail) begin
          state_d = ST_DONE_ERR;
        end else if (pif.isuccess) begin
          state_d = ST_DONE_OK;
        end else if (wd_q == WD_LAST) begin
          state_d   = ST_DONE_ERR;
          timeout_d = 1'b1;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end
      default: begin
        // result flags are ignored here, so stale levels from a past run are harmless
        if (start_req) begin
          state_d   = ST_BUSY;
          ostart_d  = 1'b1;
          timeout_d = 1'b0;
          wd_d      = '0;
          blink_d   = '0;
          phase_d   = 1'b1;
        end
      end
    endcase

    busy_d = (state_d == ST_BUSY) && phase_d;
    ok_d   = (state_d == ST_DONE_OK);
    err_d  = (state_d == ST_DONE_ERR) && (!timeout_d || phase_d);
  end

  // FSM and output registers with synchronous active-low reset.
  always_ff @(posedge iclk) begin
    if (!irst) begin
      state_q   <= ST_IDLE;
      ostart_q  <= 1'b0;
      busy_q    <= 1'b0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
      phase_q   <= 1'b0;
      wd_q      <= '0;
      blink_q   <= '0;
    end else begin
      state_q   <= state_d;
      ostart_q  <= ostart_d;
      busy_q    <= busy_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
      phase_q   <= phase_d;
      wd_q      <= wd_d;
      blink_q   <= blink_d;
    end
  end

  assign pif.ostart    = ostart_q;
  assign pif.oled_busy = busy_q;
  assign pif.oled_ok   = ok_q;
  assign pif.oled_err  = err_q;
  assign pif.otimeout  = timeout_q;

endmodule
